// File: rtl/fpu_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_dispatch_if
// Desc     : Host-side request/response channel bundle for fpu_dispatch.
//            The host drives the master modport, the dispatcher the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface fpu_dispatch_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_data1;
  logic [31:0] req_data2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  modport master (
    output req_valid, req_op, req_data1, req_data2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data1, req_data2, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/fpu_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : fpu_dispatch
// Desc     : Issue/collect front-end for the IEEE754 add and multiply units.
//            Latches one host request, pulses the selected unit's trig,
//            waits (bounded) for its vld and returns the result over a
//            valid/ready response channel.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_dispatch #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  fpu_dispatch_if.slave     host,
  output logic [31:0]       unit_data1,
  output logic [31:0]       unit_data2,
  output logic              add_trig,
  input  logic              add_vld,
  input  logic [31:0]       add_data,
  output logic              mul_trig,
  input  logic              mul_vld,
  input  logic [31:0]       mul_data,
  output logic [CNT_W-1:0]  done_cnt
);

  // Wait counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  localparam int                c_ST_W    = 2;
  localparam logic [c_ST_W-1:0] c_S_IDLE  = 2'd0;
  localparam logic [c_ST_W-1:0] c_S_ISSUE = 2'd1;
  localparam logic [c_ST_W-1:0] c_S_WAIT  = 2'd2;
  localparam logic [c_ST_W-1:0] c_S_RESP  = 2'd3;

  localparam logic [1:0]  c_OP_SUB  = 2'b01;
  localparam logic [1:0]  c_OP_MUL  = 2'b10;
  localparam logic [1:0]  c_OP_ILL  = 2'b11;

  localparam logic [1:0]  c_ERR_OK  = 2'b00;
  localparam logic [1:0]  c_ERR_ILL = 2'b01;
  localparam logic [1:0]  c_ERR_TO  = 2'b10;

  localparam logic [31:0] c_QNAN    = 32'h7FC0_0000;

  logic [c_ST_W-1:0] r_state;
  logic [c_ST_W-1:0] w_next_state;

  logic              r_sel_mul;      // 1: multiply unit selected, 0: add unit
  logic [c_TO_W-1:0] r_wait_cnt;
  logic [31:0]       r_unit_data1;
  logic [31:0]       r_unit_data2;
  logic [31:0]       r_rsp_data;
  logic [1:0]        r_rsp_err;
  logic [CNT_W-1:0]  r_done_cnt;

  logic              w_req_ready;
  logic              w_rsp_valid;
  logic              w_add_trig;
  logic              w_mul_trig;
  logic              w_accept;
  logic              w_sel_vld;
  logic [31:0]       w_sel_data;
  logic              w_timeout;
  logic              w_rsp_done;

  assign w_accept   = host.req_valid && w_req_ready;
  assign w_rsp_done = w_rsp_valid && host.rsp_ready;

  // Only the selected unit is listened to; the other unit's vld is ignored.
  assign w_sel_vld  = r_sel_mul ? mul_vld  : add_vld;
  assign w_sel_data = r_sel_mul ? mul_data : add_data;
  assign w_timeout  = (r_wait_cnt == c_TO_LAST);

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_accept) begin
          w_next_state = (host.req_op == c_OP_ILL) ? c_S_RESP : c_S_ISSUE;
        end
      end
      c_S_ISSUE: begin
        w_next_state = c_S_WAIT;
      end
      c_S_WAIT: begin
        if (w_sel_vld || w_timeout) begin
          w_next_state = c_S_RESP;
        end
      end
      c_S_RESP: begin
        if (host.rsp_ready) begin
          w_next_state = c_S_IDLE;
        end
      end
      default: begin
        w_next_state = c_S_IDLE;
      end
    endcase
  end

  // State-decoded outputs; ready is held low while reset is asserted.
  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_add_trig  = 1'b0;
    w_mul_trig  = 1'b0;
    case (r_state)
      c_S_IDLE:  w_req_ready = !sys_rst;
      c_S_ISSUE: begin
        w_add_trig = !r_sel_mul;
        w_mul_trig = r_sel_mul;
      end
      c_S_RESP:  w_rsp_valid = 1'b1;
      default:   w_req_ready = 1'b0;
    endcase
  end

  // Operand and unit-select capture; only updated when a request is accepted.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_unit_data1 <= 32'h0;
      r_unit_data2 <= 32'h0;
      r_sel_mul    <= 1'b0;
    end else if (w_accept) begin
      r_unit_data1 <= host.req_data1;
      r_unit_data2 <= (host.req_op == c_OP_SUB) ?
                      {~host.req_data2[31], host.req_data2[30:0]} :
                      host.req_data2;
      r_sel_mul    <= (host.req_op == c_OP_MUL);
    end
  end

  // Wait counter: cleared while issuing, counts WAIT cycles without vld.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == c_S_ISSUE) begin
      r_wait_cnt <= '0;
    end else if ((r_state == c_S_WAIT) && !w_sel_vld && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
    end
  end

  // Response capture: illegal op at acceptance, unit result or timeout in WAIT.
  // Held untouched through RESP so data/err stay stable under backpressure.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rsp_data <= 32'h0;
      r_rsp_err  <= c_ERR_OK;
    end else if ((r_state == c_S_IDLE) && w_accept && (host.req_op == c_OP_ILL)) begin
      r_rsp_data <= 32'h0;
      r_rsp_err  <= c_ERR_ILL;
    end else if (r_state == c_S_WAIT) begin
      if (w_sel_vld) begin
        r_rsp_data <= w_sel_data;
        r_rsp_err  <= c_ERR_OK;
      end else if (w_timeout) begin
        r_rsp_data <= c_QNAN;
        r_rsp_err  <= c_ERR_TO;
      end
    end
  end

  // Completed-operation counter, wraps naturally at its width.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_done_cnt <= '0;
    end else if (w_rsp_done) begin
      r_done_cnt <= r_done_cnt + CNT_W'(1);
    end
  end

  assign host.req_ready = w_req_ready;
  assign host.rsp_valid = w_rsp_valid;
  assign host.rsp_data  = r_rsp_data;
  assign host.rsp_err   = r_rsp_err;
  assign add_trig       = w_add_trig;
  assign mul_trig       = w_mul_trig;
  assign unit_data1     = r_unit_data1;
  assign unit_data2     = r_unit_data2;
  assign done_cnt       = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fpu_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_dispatch
// Desc     : Self-checking bench for fpu_dispatch. Directed transactions set
//            per-cycle expectations from the latency/err rules; one compare
//            process checks every cycle, plus literal pins per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_dispatch;
  localparam int          TO   = 4;
  localparam int          CW   = 2;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   unit_data1;
  logic [31:0]   unit_data2;
  logic          add_trig;
  logic          add_vld;
  logic [31:0]   add_data;
  logic          mul_trig;
  logic          mul_vld;
  logic [31:0]   mul_data;
  logic [CW-1:0] done_cnt;

  fpu_dispatch_if host ();

  fpu_dispatch #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .host       (host),
    .unit_data1 (unit_data1),
    .unit_data2 (unit_data2),
    .add_trig   (add_trig),
    .add_vld    (add_vld),
    .add_data   (add_data),
    .mul_trig   (mul_trig),
    .mul_vld    (mul_vld),
    .mul_data   (mul_data),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs for the sample after the next rising edge.
  bit          chk_en = 1'b0;
  logic        e_req_ready, e_add_trig, e_mul_trig, e_rsp_valid;
  logic [31:0] e_rsp_data, e_u1, e_u2;
  logic [1:0]  e_rsp_err;
  int          e_done = 0;

  // Event captures used by the literal checks.
  int          cyc = 0;
  int          trig_cyc = 0, rise_cyc = 0, acc_cyc = 0;
  int          n_add_trig = 0, n_mul_trig = 0;
  logic [31:0] rise_data = 32'h0, trig_u2 = 32'h0;
  logic [1:0]  rise_err = 2'b00;
  logic        prev_rv = 1'b0, prev_rr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_reset();
    e_req_ready = 1'b0; e_add_trig = 1'b0; e_mul_trig = 1'b0; e_rsp_valid = 1'b0;
    e_rsp_data  = 32'h0; e_rsp_err = 2'b00; e_u1 = 32'h0; e_u2 = 32'h0; e_done = 0;
  endtask

  // Per-cycle compare process, sampling 1 time unit after the rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (chk_en) begin
        check("req_ready",  host.req_ready, e_req_ready);
        check("add_trig",   add_trig,       e_add_trig);
        check("mul_trig",   mul_trig,       e_mul_trig);
        check("rsp_valid",  host.rsp_valid, e_rsp_valid);
        check("unit_data1", unit_data1,     e_u1);
        check("unit_data2", unit_data2,     e_u2);
        check("done_cnt",   done_cnt,       e_done % (1 << CW));
        if (e_rsp_valid) begin
          check("rsp_data", host.rsp_data, e_rsp_data);
          check("rsp_err",  host.rsp_err,  e_rsp_err);
        end
      end
      if (add_trig === 1'b1) begin n_add_trig++; trig_cyc = cyc; trig_u2 = unit_data2; end
      if (mul_trig === 1'b1) begin n_mul_trig++; trig_cyc = cyc; trig_u2 = unit_data2; end
      if (host.rsp_valid === 1'b1 && prev_rv !== 1'b1) begin
        rise_cyc = cyc; rise_data = host.rsp_data; rise_err = host.rsp_err;
      end
      if (host.req_valid === 1'b1 && prev_rr === 1'b1) acc_cyc = cyc - 1;
      prev_rv = host.rsp_valid;
      prev_rr = host.req_ready;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; host.req_valid = 1'b0; host.rsp_ready = 1'b0; add_vld = 1'b0; mul_vld = 1'b0;
    expect_reset();
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e_req_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      host.req_valid = 1'b0; host.rsp_ready = 1'b0; add_vld = 1'b0; mul_vld = 1'b0;
    end
  endtask

  // Let the edge after the last driven negedge land before literal checks.
  task automatic settle();
    @(posedge clk); #2;
  endtask

  // One transaction starting in an IDLE cycle.
  // vld_at: WAIT cycle (1-based) carrying the selected vld, 0 = never.
  // rdy_wait: RESP cycles with rsp_ready low before the handshake.
  // junk: pulse the non-selected unit's vld in WAIT. late: selected vld in RESP.
  // hold: keep req_valid high while busy. rst_at: WAIT cycle to assert reset.
  task automatic do_op(input logic [1:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] res, input int vld_at, input int rdy_wait,
                       input bit junk, input bit late, input bit hold, input int rst_at);
    logic [31:0] d2x;
    bit          is_mul;
    bit          hit;
    d2x    = (op == 2'b01) ? {~d2[31], d2[30:0]} : d2;
    is_mul = (op == 2'b10);
    @(negedge clk);
    host.rsp_ready = 1'b0; add_vld = 1'b0; mul_vld = 1'b0;
    host.req_valid = 1'b1; host.req_op = op; host.req_data1 = d1; host.req_data2 = d2;
    e_req_ready = 1'b0; e_u1 = d1; e_u2 = d2x;
    if (op == 2'b11) begin
      e_rsp_valid = 1'b1; e_rsp_data = 32'h0; e_rsp_err = 2'b01;
    end else begin
      e_add_trig = !is_mul; e_mul_trig = is_mul;
      @(negedge clk);
      host.req_valid = hold;
      e_add_trig = 1'b0; e_mul_trig = 1'b0;
      for (int k = 1; k <= TO; k++) begin
        @(negedge clk);
        if (k == rst_at) begin
          rst = 1'b1; add_vld = 1'b0; mul_vld = 1'b0; host.req_valid = 1'b0;
          expect_reset();
          @(negedge clk);
          rst = 1'b0;
          e_req_ready = 1'b1;
          if (is_mul) mul_vld = 1'b1; else add_vld = 1'b1;
          @(negedge clk);
          add_vld = 1'b0; mul_vld = 1'b0;
          return;
        end
        hit = (k == vld_at);
        if (is_mul) begin
          mul_vld = hit; mul_data = res;
          add_vld = junk && (k % 2 == 1); add_data = 32'h1111_1111;
        end else begin
          add_vld = hit; add_data = res;
          mul_vld = junk && (k % 2 == 1); mul_data = 32'h2222_2222;
        end
        if (hit) begin
          e_rsp_valid = 1'b1; e_rsp_data = res; e_rsp_err = 2'b00;
          break;
        end
        if (k == TO) begin
          e_rsp_valid = 1'b1; e_rsp_data = QNAN; e_rsp_err = 2'b10;
        end
      end
    end
    for (int j = 0; j <= rdy_wait; j++) begin
      @(negedge clk);
      host.req_valid = hold; add_vld = 1'b0; mul_vld = 1'b0;
      if (late && j == 0) begin
        if (is_mul) begin mul_vld = 1'b1; mul_data = 32'hDEAD_BEEF; end
        else begin add_vld = 1'b1; add_data = 32'hDEAD_BEEF; end
      end
      host.rsp_ready = (j == rdy_wait);
      if (j == rdy_wait) begin
        e_rsp_valid = 1'b0; e_req_ready = 1'b1; e_done++;
      end
    end
  endtask

  // Directed scenario sequence.
  initial begin
    int na, nm, r1;
    rst = 1'b1;
    host.req_valid = 1'b0; host.req_op = 2'b00; host.req_data1 = 32'h0; host.req_data2 = 32'h0;
    host.rsp_ready = 1'b0;
    add_vld = 1'b0; add_data = 32'h0; mul_vld = 1'b0; mul_data = 32'h0;
    repeat (2) @(negedge clk);
    do_reset();
    check("reset_done_cnt",  done_cnt,       32'd0);
    check("reset_rsp_valid", host.rsp_valid, 32'd0);

    // Add 1.0 + 2.0, vld two cycles after trig.
    na = n_add_trig; nm = n_mul_trig;
    do_op(2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 2, 0, 1'b0, 1'b0, 1'b0, 0);
    settle();
    check("add_rsp_data",   rise_data, 32'h4040_0000);
    check("add_rsp_err",    rise_err,  32'd0);
    check("add_trig_to_rv", rise_cyc - trig_cyc, 32'd3);
    check("add_trig_count", n_add_trig - na, 32'd1);
    check("add_mul_quiet",  n_mul_trig - nm, 32'd0);

    // Sub sign flip in both directions.
    do_op(2'b01, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 1, 0, 1'b0, 1'b0, 1'b0, 0);
    settle();
    check("sub_flip_pos", trig_u2, 32'hC000_0000);
    do_op(2'b01, 32'h3F80_0000, 32'hC000_0000, 32'h4040_0000, 3, 0, 1'b0, 1'b0, 1'b0, 0);
    settle();
    check("sub_flip_neg", trig_u2, 32'h4000_0000);

    // Mul with add_vld noise and 4 cycles of backpressure; 4th op wraps done_cnt.
    na = n_add_trig; nm = n_mul_trig;
    do_op(2'b10, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4, 4, 1'b1, 1'b0, 1'b0, 0);
    settle();
    check("mul_rsp_data",   rise_data, 32'h4040_0000);
    check("mul_trig_count", n_mul_trig - nm, 32'd1);
    check("mul_add_quiet",  n_add_trig - na, 32'd0);
    check("done_wrap",      done_cnt, 32'd0);

    // Timeout with a late vld during RESP.
    do_op(2'b00, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 0, 1, 1'b0, 1'b1, 1'b0, 0);
    settle();
    check("to_rsp_data",   rise_data, QNAN);
    check("to_rsp_err",    rise_err,  32'd2);
    check("to_trig_to_rv", rise_cyc - trig_cyc, 32'd5);
    check("to_done_cnt",   done_cnt,  32'd1);

    // Reset in the 2nd WAIT cycle aborts the operation.
    do_op(2'b10, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 0, 0, 1'b0, 1'b0, 1'b0, 2);
    check("rst_done_cnt",  done_cnt,       32'd0);
    check("rst_rsp_valid", host.rsp_valid, 32'd0);
    idle(3);

    // vld on the final permitted WAIT cycle beats the timeout.
    do_op(2'b00, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 4, 0, 1'b0, 1'b0, 1'b0, 0);
    settle();
    check("last_vld_data",  rise_data, 32'h4080_0000);
    check("last_vld_err",   rise_err,  32'd0);
    check("last_vld_to_rv", rise_cyc - trig_cyc, 32'd5);

    // Illegal op with req_valid held through RESP, then back-to-back repeat.
    na = n_add_trig; nm = n_mul_trig;
    do_op(2'b11, 32'hAAAA_5555, 32'h1234_5678, 32'h0, 0, 0, 1'b0, 1'b0, 1'b1, 0);
    settle();
    check("ill_acc_to_rv", rise_cyc - acc_cyc, 32'd1);
    check("ill_rsp_data",  rise_data, 32'h0);
    check("ill_rsp_err",   rise_err,  32'd1);
    r1 = rise_cyc;
    do_op(2'b11, 32'hAAAA_5555, 32'h1234_5678, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    settle();
    check("ill_bubble",    rise_cyc - r1, 32'd2);
    check("ill_no_trig",   (n_add_trig - na) + (n_mul_trig - nm), 32'd0);

    // Minimum-latency mul, then an add with one cycle of backpressure.
    do_op(2'b10, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1, 0, 1'b0, 1'b0, 1'b0, 0);
    settle();
    check("min_latency", rise_cyc - acc_cyc, 32'd3);
    do_op(2'b00, 32'h4040_0000, 32'h4000_0000, 32'h40A0_0000, 2, 1, 1'b0, 1'b0, 1'b0, 0);
    settle();
    check("done_after_5", done_cnt, 32'd1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
